// File: rtl/led_band_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_band_pkg
// Description : Shared state encoding and LED-driver command lengths for the
//               LED band sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package led_band_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GS_SHIFT = 3'd1,
    ST_FC_EN    = 3'd2,
    ST_FC_SHIFT = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int NB_COLORS   = 3;   // colors shifted per LED row
  localparam int WRTGS_LAT   = 1;   // LAT pulses closing each non-final row
  localparam int LATGS_LAT   = 3;   // LAT pulses closing the final row
  localparam int FCWRTEN_LEN = 15;  // FC write-enable command length
  localparam int WRTFC_LEN   = 48;  // FC data shift length
  localparam int WRTFC_LAT   = 5;   // LAT pulses closing the FC data shift

endpackage
`default_nettype wire

// File: rtl/led_band_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_band_sclk_gen
// Description : Shift clock generator. While run_i is high it emits symbols of
//               CLK_DIV low cycles followed by CLK_DIV high cycles, plus
//               strobes flagging the cycle before SCLK rises / falls.
// Revision    : 1.0 - initial release
// ============================================================================
module led_band_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] HIGH_START = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] RISE_AT    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2 * CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  // Phase counter restarts whenever the generator is idle so every sequence
  // begins with a full low phase.
  always_comb begin
    cnt_d = '0;
    if (run_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
    sclk_d = run_i && (cnt_d >= HIGH_START);
  end

  // Phase counter and glitch-free registered SCLK level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = run_i && (cnt_q == RISE_AT);
  assign fall_o = run_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/led_band_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_band_sequencer
// Description : Drives the SCLK/LAT serial interface of an LED driver chain.
//               An angle tick shifts one grayscale frame (rows x colors x
//               bits, MSB first); an FC request issues the FC write-enable
//               and FC data commands. Requests are held in one-deep pending
//               flags, FC wins arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module led_band_sequencer #(
  parameter int NB_LED_ROWS       = 32,
  parameter int NB_ANGLES         = 128,
  parameter int COLOR_DATA_WIDTH  = 8,
  parameter int NB_ADDED_LSB_BITS = 1,
  parameter int CLK_DIV           = 2
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                enable,
  input  logic                                                angle_tick,
  input  logic [$clog2(NB_ANGLES)-1:0]                        angle_in,
  input  logic                                                fc_req,
  output logic                                                SCLK,
  output logic                                                LAT,
  output logic [$clog2(NB_ANGLES)-1:0]                        angle,
  output logic [$clog2(NB_LED_ROWS)-1:0]                      led_row,
  output logic [1:0]                                          color,
  output logic [$clog2(COLOR_DATA_WIDTH+NB_ADDED_LSB_BITS)-1:0] bit_sel,
  output logic                                                busy,
  output logic                                                frame_done,
  output logic                                                fc_done,
  output logic                                                overrun
);

  import led_band_pkg::*;

  localparam int BITS    = COLOR_DATA_WIDTH + NB_ADDED_LSB_BITS;
  localparam int ANGLE_W = $clog2(NB_ANGLES);
  localparam int ROW_W   = $clog2(NB_LED_ROWS);
  localparam int BIT_W   = $clog2(BITS);
  localparam int FC_W    = $clog2(WRTFC_LEN);

  localparam logic [ROW_W-1:0] LAST_ROW        = ROW_W'(NB_LED_ROWS - 1);
  localparam logic [BIT_W-1:0] TOP_BIT         = BIT_W'(BITS - 1);
  localparam logic [1:0]       LAST_COLOR      = 2'(NB_COLORS - 1);
  localparam logic [BIT_W-1:0] WRTGS_B         = BIT_W'(WRTGS_LAT);
  localparam logic [BIT_W-1:0] LATGS_B         = BIT_W'(LATGS_LAT);
  localparam logic [FC_W-1:0]  FCWRTEN_LAST    = FC_W'(FCWRTEN_LEN - 1);
  localparam logic [FC_W-1:0]  WRTFC_LAST      = FC_W'(WRTFC_LEN - 1);
  localparam logic [FC_W-1:0]  WRTFC_LAT_FIRST = FC_W'(WRTFC_LEN - WRTFC_LAT);

  state_e             state_q;
  logic [ANGLE_W-1:0] angle_q, angle_pend_q;
  logic [ROW_W-1:0]   row_q;
  logic [1:0]         color_q;
  logic [BIT_W-1:0]   bit_q;
  logic [FC_W-1:0]    fc_cnt_q, fc_cnt_d;
  logic               lat_q, busy_q, frame_done_q, fc_done_q, overrun_q;
  logic               tick_pend_q, fc_pend_q, armed_q;

  logic               take_fc, take_gs, tick_accept;
  logic               tick_pend_d, fc_pend_d, overrun_d;
  logic [ROW_W-1:0]   row_d;
  logic [1:0]         color_d;
  logic [BIT_W-1:0]   bit_d;
  logic               gs_last;
  logic               run, sclk, sclk_rise, sclk_fall, sym_adv;

  // LAT level for a grayscale symbol: WRTGS closes ordinary rows, LATGS
  // closes the last row of the frame.
  function automatic logic gs_lat(input logic [ROW_W-1:0] row,
                                  input logic [1:0]       col,
                                  input logic [BIT_W-1:0] b);
    if (col != LAST_COLOR) return 1'b0;
    if (row == LAST_ROW)   return (b < LATGS_B);
    return (b < WRTGS_B);
  endfunction

  assign run = (state_q == ST_GS_SHIFT) || (state_q == ST_FC_EN) ||
               (state_q == ST_FC_SHIFT);

  led_band_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run),
    .sclk_o (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // A symbol only advances once its rising edge has actually been issued.
  assign sym_adv  = sclk_fall && armed_q;
  assign fc_cnt_d = fc_cnt_q + 1'b1;

  // Request arbitration and pending-flag bookkeeping; a request arriving in
  // the cycle its pending flag is consumed is kept, not counted as overrun.
  always_comb begin
    take_fc     = (state_q == ST_IDLE) && enable && fc_pend_q;
    take_gs     = (state_q == ST_IDLE) && enable && !fc_pend_q && tick_pend_q;
    tick_accept = angle_tick && (!tick_pend_q || take_gs);
    overrun_d   = angle_tick && tick_pend_q && !take_gs;
    tick_pend_d = tick_accept || (tick_pend_q && !take_gs);
    fc_pend_d   = fc_req || (fc_pend_q && !take_fc);
  end

  // Next grayscale position: bit counts down, then color, then row; the
  // final symbol saturates and raises gs_last instead of wrapping.
  always_comb begin
    row_d   = row_q;
    color_d = color_q;
    bit_d   = bit_q;
    gs_last = 1'b0;
    if (bit_q != '0) begin
      bit_d = bit_q - 1'b1;
    end else if (color_q != LAST_COLOR) begin
      color_d = color_q + 1'b1;
      bit_d   = TOP_BIT;
    end else if (row_q != LAST_ROW) begin
      row_d   = row_q + 1'b1;
      color_d = '0;
      bit_d   = TOP_BIT;
    end else begin
      gs_last = 1'b1;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      angle_q      <= '0;
      angle_pend_q <= '0;
      row_q        <= '0;
      color_q      <= '0;
      bit_q        <= '0;
      fc_cnt_q     <= '0;
      lat_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      fc_done_q    <= 1'b0;
      overrun_q    <= 1'b0;
      tick_pend_q  <= 1'b0;
      fc_pend_q    <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      tick_pend_q  <= tick_pend_d;
      fc_pend_q    <= fc_pend_d;
      overrun_q    <= overrun_d;
      frame_done_q <= 1'b0;
      fc_done_q    <= 1'b0;
      if (tick_accept) angle_pend_q <= angle_in;
      if (sym_adv) begin
        armed_q <= 1'b0;
      end else if (sclk_rise) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (take_fc) begin
            state_q  <= ST_FC_EN;
            busy_q   <= 1'b1;
            row_q    <= '0;
            color_q  <= '0;
            bit_q    <= '0;
            fc_cnt_q <= '0;
            lat_q    <= 1'b1;
          end else if (take_gs) begin
            state_q <= ST_GS_SHIFT;
            busy_q  <= 1'b1;
            angle_q <= angle_pend_q;
            row_q   <= '0;
            color_q <= '0;
            bit_q   <= TOP_BIT;
            lat_q   <= gs_lat('0, '0, TOP_BIT);
          end
        end

        ST_GS_SHIFT: begin
          if (sym_adv) begin
            if (gs_last) begin
              state_q      <= ST_DONE;
              lat_q        <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              row_q   <= row_d;
              color_q <= color_d;
              bit_q   <= bit_d;
              lat_q   <= gs_lat(row_d, color_d, bit_d);
            end
          end
        end

        ST_FC_EN: begin
          if (sym_adv) begin
            if (fc_cnt_q == FCWRTEN_LAST) begin
              state_q  <= ST_FC_SHIFT;
              fc_cnt_q <= '0;
              lat_q    <= 1'b0;
            end else begin
              fc_cnt_q <= fc_cnt_d;
            end
          end
        end

        ST_FC_SHIFT: begin
          if (sym_adv) begin
            if (fc_cnt_q == WRTFC_LAST) begin
              state_q   <= ST_DONE;
              lat_q     <= 1'b0;
              fc_done_q <= 1'b1;
            end else begin
              fc_cnt_q <= fc_cnt_d;
              lat_q    <= (fc_cnt_d >= WRTFC_LAT_FIRST);
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          lat_q   <= 1'b0;
        end
      endcase
    end
  end

  assign SCLK       = sclk;
  assign LAT        = lat_q;
  assign angle      = angle_q;
  assign led_row    = row_q;
  assign color      = color_q;
  assign bit_sel    = bit_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign fc_done    = fc_done_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_led_band_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_band_sequencer
// Description : Directed self-checking bench for led_band_sequencer with
//               2 rows, 9 bits per color and CLK_DIV=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_band_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, angle_tick, fc_req;
  logic [6:0] angle_in;
  logic       SCLK, LAT, busy, frame_done, fc_done, overrun;
  logic [6:0] angle;
  logic       led_row;
  logic [1:0] color;
  logic [3:0] bit_sel;

  int total = 0;
  int bad   = 0;

  // Event monitor: pulse records and pulse counters.
  int         pulse_cnt = 0;
  int         fd_cnt = 0, fcd_cnt = 0, ov_cnt = 0;
  logic       prev_sclk = 1'b0;
  logic       lat_rec [0:1023];
  logic [6:0] rcb_rec [0:1023];

  int         base, f0, c0, o0, cyc, lat_sum;
  logic [6:0] acc;

  led_band_sequencer #(
    .NB_LED_ROWS       (2),
    .NB_ANGLES         (128),
    .COLOR_DATA_WIDTH  (8),
    .NB_ADDED_LSB_BITS (1),
    .CLK_DIV           (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .angle_tick (angle_tick),
    .angle_in   (angle_in),
    .fc_req     (fc_req),
    .SCLK       (SCLK),
    .LAT        (LAT),
    .angle      (angle),
    .led_row    (led_row),
    .color      (color),
    .bit_sel    (bit_sel),
    .busy       (busy),
    .frame_done (frame_done),
    .fc_done    (fc_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Sample one time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (SCLK && !prev_sclk) begin
      if (pulse_cnt < 1024) begin
        lat_rec[pulse_cnt] = LAT;
        rcb_rec[pulse_cnt] = {led_row, color, bit_sel};
      end
      pulse_cnt++;
    end
    prev_sclk = SCLK;
    if (frame_done) fd_cnt++;
    if (fc_done)    fcd_cnt++;
    if (overrun)    ov_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [6:0] a);
    @(negedge clk);
    angle_tick = 1'b1;
    angle_in   = a;
    @(negedge clk);
    angle_tick = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int start;
    int n;
    start = fd_cnt;
    n = 0;
    while (fd_cnt == start && n < 700) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(fd_cnt != start), 1);
  endtask

  task automatic wait_fcd(input string tag);
    int start;
    int n;
    start = fcd_cnt;
    n = 0;
    while (fcd_cnt == start && n < 700) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(fcd_cnt != start), 1);
  endtask

  task automatic wait_pulse(input int target, input string tag);
    int n;
    n = 0;
    while (!((pulse_cnt - base) >= target && SCLK) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, pulse_cnt - base, target);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; angle_tick = 1'b0; fc_req = 1'b0; angle_in = '0;
    repeat (3) @(negedge clk);
    check("rst_sclk", SCLK, 0);
    check("rst_lat", LAT, 0);
    check("rst_busy", busy, 0);
    check("rst_pos", {angle, led_row, color, bit_sel}, 0);
    check("rst_pulses", {frame_done, fc_done, overrun}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_start_after_rst", pulse_cnt, 0);

    // Single grayscale frame, angle 37.
    base = pulse_cnt; f0 = fd_cnt;
    angle_in = 7'd37; angle_tick = 1'b1; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin angle_tick = 1'b0; angle_in = '0; end
      if (cyc == 10) begin
        check("gs_busy", busy, 1);
        check("gs_angle_mid", angle, 37);
      end
    end while (!frame_done && cyc < 400);
    check("gs_latency", cyc, 218);
    check("done_sclk_lat", {SCLK, LAT}, 0);
    repeat (5) @(negedge clk);
    check("gs_pulses", pulse_cnt - base, 54);
    check("gs_fd_once", fd_cnt - f0, 1);
    check("gs_idle_busy", busy, 0);
    check("gs_angle_after", angle, 37);
    lat_sum = 0;
    for (int i = 0; i < 54; i++) lat_sum += int'(lat_rec[base + i]);
    check("gs_lat_count", lat_sum, 4);
    check("gs_lat_p26", lat_rec[base + 25], 0);
    check("gs_lat_p27", lat_rec[base + 26], 1);
    check("gs_lat_p51", lat_rec[base + 50], 0);
    check("gs_lat_p52", lat_rec[base + 51], 1);
    check("gs_lat_p54", lat_rec[base + 53], 1);
    check("gs_pos_p1", rcb_rec[base + 0], {1'b0, 2'd0, 4'd8});
    check("gs_pos_p10", rcb_rec[base + 9], {1'b0, 2'd1, 4'd8});
    check("gs_pos_p27", rcb_rec[base + 26], {1'b0, 2'd2, 4'd0});
    check("gs_pos_p28", rcb_rec[base + 27], {1'b1, 2'd0, 4'd8});
    check("gs_pos_p54", rcb_rec[base + 53], {1'b1, 2'd2, 4'd0});

    // FC command sequence.
    base = pulse_cnt; f0 = fd_cnt;
    @(negedge clk); fc_req = 1'b1;
    @(negedge clk); fc_req = 1'b0;
    wait_fcd("fc_done_seen");
    repeat (3) @(negedge clk);
    check("fc_pulses", pulse_cnt - base, 63);
    check("fc_no_frame", fd_cnt - f0, 0);
    lat_sum = 0; acc = '0;
    for (int i = 0; i < 63; i++) begin
      lat_sum += int'(lat_rec[base + i]);
      acc |= rcb_rec[base + i];
    end
    check("fc_lat_count", lat_sum, 20);
    check("fc_lat_p15", lat_rec[base + 14], 1);
    check("fc_lat_p16", lat_rec[base + 15], 0);
    check("fc_lat_p58", lat_rec[base + 57], 0);
    check("fc_lat_p59", lat_rec[base + 58], 1);
    check("fc_lat_p63", lat_rec[base + 62], 1);
    check("fc_pos_zero", acc, 0);

    // Simultaneous FC request and tick: FC first, then GS.
    base = pulse_cnt; f0 = fd_cnt;
    @(negedge clk); fc_req = 1'b1; angle_tick = 1'b1; angle_in = 7'd20;
    @(negedge clk); fc_req = 1'b0; angle_tick = 1'b0; angle_in = '0;
    wait_fcd("both_fc_done");
    check("both_gs_not_yet", fd_cnt - f0, 0);
    check("both_fc_pulses", pulse_cnt - base, 63);
    wait_fd("both_gs_done");
    check("both_total_pulses", pulse_cnt - base, 117);
    check("both_angle", angle, 20);
    check("both_gs_lat_p27", lat_rec[base + 63 + 26], 1);

    // Three ticks around one frame: one pending, one dropped.
    repeat (5) @(negedge clk);
    f0 = fd_cnt; o0 = ov_cnt;
    tick(7'd5);
    repeat (30) @(negedge clk);
    tick(7'd9);
    repeat (30) @(negedge clk);
    tick(7'd11);
    wait_fd("ovr_first_done");
    check("ovr_count", ov_cnt - o0, 1);
    repeat (10) @(negedge clk);
    check("ovr_next_busy", busy, 1);
    check("ovr_next_angle", angle, 9);
    wait_fd("ovr_second_done");
    repeat (300) @(negedge clk);
    check("ovr_frames", fd_cnt - f0, 2);
    check("ovr_count_final", ov_cnt - o0, 1);

    // Enable dropped after a frame starts.
    f0 = fd_cnt;
    tick(7'd50);
    @(negedge clk);
    check("en_started", busy, 1);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    tick(7'd60);
    wait_fd("en_frame_completes");
    repeat (40) @(negedge clk);
    check("en_held_busy", busy, 0);
    check("en_held_frames", fd_cnt - f0, 1);
    enable = 1'b1;
    wait_fd("en_pending_runs");
    check("en_pending_angle", angle, 60);
    check("en_frames", fd_cnt - f0, 2);

    // Reset at GS pulse 20 with a tick pending.
    repeat (5) @(negedge clk);
    base = pulse_cnt;
    tick(7'd70);
    wait_pulse(10, "rst_gs_p10");
    tick(7'd71);
    wait_pulse(20, "rst_gs_p20");
    check("rst_pre_sclk", SCLK, 1);
    check("rst_pre_pos", {led_row, color, bit_sel}, {1'b0, 2'd2, 4'd7});
    rst = 1'b1;
    #1;
    check("rst_mid_sclk_lat", {SCLK, LAT}, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pos", {angle, led_row, color, bit_sel}, 0);
    @(negedge clk);
    rst = 1'b0;
    base = pulse_cnt; f0 = fd_cnt;
    repeat (300) @(negedge clk);
    check("rst_no_activity", pulse_cnt - base, 0);
    check("rst_no_frame", fd_cnt - f0, 0);
    tick(7'd3);
    wait_fd("rst_restart_done");
    check("rst_restart_pulses", pulse_cnt - base, 54);
    check("rst_restart_angle", angle, 3);

    // Reset during FC write-enable, where LAT is high.
    repeat (5) @(negedge clk);
    base = pulse_cnt; c0 = fcd_cnt;
    @(negedge clk); fc_req = 1'b1;
    @(negedge clk); fc_req = 1'b0;
    wait_pulse(5, "rst_fc_p5");
    check("rst_fc_pre_lat", LAT, 1);
    rst = 1'b1;
    #1;
    check("rst_fc_sclk_lat", {SCLK, LAT}, 0);
    @(negedge clk);
    rst = 1'b0;
    base = pulse_cnt;
    repeat (100) @(negedge clk);
    check("rst_fc_quiet", pulse_cnt - base, 0);
    check("rst_fc_no_done", fcd_cnt - c0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
